alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage that feeds the ALU. Accepts one fetched RV32I instruction per handshake, drives register-file read addresses, and selects operands (register, PC, or immediate). It decodes the ALU operation and condition flag, then registers the result into a valid/ready output stage consumed by the execute stage. It sits between fetch/regfile and the ALU and is the sole producer of the ALU's `op1`, `op2`, `op` and `is_cond` inputs.

## Interface
- `XLEN`, 32, datapath width; matches `` `XLEN `` in `defs.v`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept an instruction.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `rs1_addr`, `rs2_addr`  out  5  regfile read addresses; combinational from `in_instr[19:15]` and `in_instr[24:20]`.
- `rs1_data`, `rs2_data`  in  XLEN  regfile read data; valid in the same cycle.
- `flush`  in  1  discard all held and incoming instructions.
- `out_valid`  out  1  issued operation present.
- `out_ready`  in  1  execute stage accepts.
- `out_op1`, `out_op2`  out  XLEN  ALU operands.
- `out_op`  out  `` `ALU_OP_MSB ``+1  ALU operation code.
- `out_is_cond`  out  1  comparison op (branch).
- `out_rd`  out  5  destination register.
- `out_wb_en`  out  1  writeback required.
- `out_br_target`  out  XLEN  `in_pc` + B-immediate for branches, else 0.
- `out_illegal`  out  1  unsupported encoding.

## Operation
- **OP (0110011):** op1=rs1, op2=rs2. Decode funct3 plus funct7[5] to ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. funct7 values other than 0x00 and 0x20 (and 0x20 on funct3 values other than 000 and 101) → illegal.
- **OP-IMM (0010011):** op2 = sign-extended I-immediate.
  - SLLI/SRLI/SRAI: op2 = zero-extended shamt `instr[24:20]`.
  - funct7 other than 0x00, or 0x20 on SRAI → illegal.
- **LUI:** op1=0, op2=U-immediate, ADD.
- **AUIPC:** op1=`in_pc`, op2=U-immediate, ADD.
- **BRANCH (1100011):** op1=rs1, op2=rs2, `out_is_cond`=1, `out_wb_en`=0.
  - funct3 000/001/100/101/110/111 → EQ/NE/LT/GE/LTU/GEU.
  - funct3 010/011 → illegal.
  - `out_br_target` = `in_pc` + sign-extended B-immediate, modulo 2^XLEN.
- **Any other opcode, or illegal encoding:** `out_illegal`=1, op=ADD, op1=op2=0, wb_en=0, is_cond=0. The instruction still issues normally.
- `out_wb_en`=0 whenever rd=0.
- **Handshake:**
  - Input transfer when `in_valid && in_ready`.
  - Output transfer when `out_valid && out_ready`.
  - No loss, duplication or reordering.
  - Output payload stable while `out_valid && !out_ready`.
- **Flush:**
  - Next cycle `out_valid`=0 and the skid buffer is empty.
  - An input handshake in the flush cycle is dropped.
  - `flush` has priority over every simultaneous event.

## Timing
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready`=1.
- Reset, asynchronous:
  - `out_valid`=0 and all `out_*` payloads are 0.
  - Skid buffer is empty.
  - `in_ready`=1 from the first cycle after `rst_n` deasserts.
- Reset asserted mid-stall discards all held instructions.
- Only the decode path is combinational from `in_instr` and `rs*_data`; every `out_*` signal is driven from a register.

## Configuration
- **`ALU_ISSUE_SKID_EN` defined:** a one-entry skid buffer sits behind the output register.
  - `in_ready` is registered and equals "skid empty".
  - No combinational path from `out_ready` to `in_ready`.
  - Under stall, one extra instruction is absorbed before `in_ready` drops.
- **Not defined:** single output register; `in_ready = !out_valid || out_ready`, a combinational path.
- Functional ordering and payload are identical in both builds.

## Structure
- `defs.v` holds the shared constants:
  - `` `ALU_OP_* `` codes and `` `ALU_OP_MSB ``.
  - `` `XLEN `` and `` `XBUS ``.
  - Opcode constants: `` `OPC_OP ``, `` `OPC_OP_IMM ``, `` `OPC_LUI ``, `` `OPC_AUIPC ``, `` `OPC_BRANCH ``.
- One sub-module: `alu_decode`, purely combinational. It maps instruction, PC and rs data to the payload bundle. `alu_issue` contains only handshake, registers and the skid buffer.

## Test plan
- **ADD:** `0x002081B3` with rs1_data=5, rs2_data=7 → next cycle out_valid=1, op1=5, op2=7, op=ADD, rd=3, wb_en=1, is_cond=0.
- **ADDI:** `0xFFF00093` (x1 = x0 + (−1)) → op2=`0xFFFFFFFF`, op=ADD, rd=1, wb_en=1.
- **BEQ:** `0x00208463` at pc=`0x100` → is_cond=1, op=EQ, br_target=`0x108`, wb_en=0. With funct3=010 (`0x0020A463`) → illegal=1, wb_en=0.
- **Backpressure:** 4 back-to-back instructions with out_ready=0 for 3 cycles → all 4 emerge in order, payload stable while stalled.
  - Skid build: in_ready falls after the 2nd accept.
  - Non-skid build: in_ready=0 in the cycle after the 1st accept.
- **Flush:** during a stall with skid full and in_valid=1 → next cycle out_valid=0; the first post-flush instruction issues with 1-cycle latency.
- **Reset:** rst_n pulsed low mid-stall → outputs 0 immediately (asynchronous); no stale instruction appears after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// ============================================================================
// Module   : alu_issue_pkg
// Brief    : Shared widths, ALU op codes, opcodes and issue payload type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_pkg;

    localparam int XLEN       = 32;
    localparam int ALU_OP_MSB = 3;

    typedef enum logic [ALU_OP_MSB:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11,
        ALU_LT   = 4'd12,
        ALU_GE   = 4'd13,
        ALU_LTU  = 4'd14,
        ALU_GEU  = 4'd15
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        alu_op_e         op;
        logic            is_cond;
        logic [4:0]      rd;
        logic            wb_en;
        logic [XLEN-1:0] br_target;
        logic            illegal;
    } issue_payload_t;

    // funct3 -> ALU op for OP / OP-IMM; alt selects SUB/SRA (funct7[5]).
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e r;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decode.sv
// ============================================================================
// Module   : alu_decode
// Brief    : Combinational RV32I decode of one instruction into the issue payload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output issue_payload_t  o_payload
);

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic [4:0]      w_shamt;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_b;
    logic            w_legal;
    logic            w_writes;
    issue_payload_t  w_pl;

    assign w_opcode = i_instr[6:0];
    assign w_rd     = i_instr[11:7];
    assign w_funct3 = i_instr[14:12];
    assign w_shamt  = i_instr[24:20];
    assign w_funct7 = i_instr[31:25];
    assign w_imm_i  = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_u  = {i_instr[31:12], 12'b0};
    assign w_imm_b  = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};

    always_comb begin
        w_pl     = '0;
        w_legal  = 1'b1;
        w_writes = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_pl.op1 = i_rs1_data;
                w_pl.op2 = i_rs2_data;
                w_pl.op  = alu_op_from_f3(w_funct3, w_funct7[5]);
                w_writes = 1'b1;
                if (w_funct7 == F7_ALT) begin
                    w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
                end else if (w_funct7 != F7_BASE) begin
                    w_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                w_pl.op1 = i_rs1_data;
                w_pl.op2 = w_imm_i;
                w_pl.op  = alu_op_from_f3(w_funct3, 1'b0);
                w_writes = 1'b1;
                // Shift immediates reuse the top bits as funct7; only SRAI may set bit 30.
                if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
                    w_pl.op2 = {{(XLEN-5){1'b0}}, w_shamt};
                    w_pl.op  = alu_op_from_f3(w_funct3, w_funct7[5]);
                    w_legal  = (w_funct7 == F7_BASE) ||
                               ((w_funct7 == F7_ALT) && (w_funct3 == 3'b101));
                end
            end
            OPC_LUI: begin
                w_pl.op2 = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_AUIPC: begin
                w_pl.op1 = i_pc;
                w_pl.op2 = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_BRANCH: begin
                w_pl.op1       = i_rs1_data;
                w_pl.op2       = i_rs2_data;
                w_pl.is_cond   = 1'b1;
                w_pl.br_target = i_pc + w_imm_b;
                case (w_funct3)
                    3'b000:  w_pl.op = ALU_EQ;
                    3'b001:  w_pl.op = ALU_NE;
                    3'b100:  w_pl.op = ALU_LT;
                    3'b101:  w_pl.op = ALU_GE;
                    3'b110:  w_pl.op = ALU_LTU;
                    3'b111:  w_pl.op = ALU_GEU;
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase

        // Illegal encodings still issue, but as an inert ADD 0,0 with no side effects.
        if (!w_legal) begin
            w_pl         = '0;
            w_pl.illegal = 1'b1;
        end else begin
            w_pl.rd    = w_writes ? w_rd : 5'd0;
            w_pl.wb_en = w_writes && (w_rd != 5'd0);
        end
    end

    assign o_payload = w_pl;

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// ============================================================================
// Module   : alu_issue
// Brief    : Decode-and-issue stage feeding the ALU through a valid/ready register.
// Config   : ALU_ISSUE_SKID_EN adds a one-entry skid buffer with registered in_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue
    import alu_issue_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_op1,
    output logic [XLEN-1:0]     out_op2,
    output logic [ALU_OP_MSB:0] out_op,
    output logic                out_is_cond,
    output logic [4:0]          out_rd,
    output logic                out_wb_en,
    output logic [XLEN-1:0]     out_br_target,
    output logic                out_illegal
);

    issue_payload_t w_dec;
    issue_payload_t out_pl_q, out_pl_d;
    logic           out_valid_q, out_valid_d;
    logic           w_acc;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    alu_decode u_decode (
        .i_instr    (in_instr),
        .i_pc       (in_pc),
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .o_payload  (w_dec)
    );

`ifdef ALU_ISSUE_SKID_EN
    issue_payload_t skid_pl_q, skid_pl_d;
    logic           skid_valid_q, skid_valid_d;
    logic           in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;
    assign w_acc    = in_valid && in_ready_q && !flush;

    always_comb begin
        out_pl_d     = out_pl_q;
        out_valid_d  = out_valid_q;
        skid_pl_d    = skid_pl_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // in_ready_q is low whenever skid holds data, so w_acc cannot collide here.
            if (skid_valid_q) begin
                out_pl_d     = skid_pl_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = w_acc;
                if (w_acc) begin
                    out_pl_d = w_dec;
                end
            end
        end else if (w_acc) begin
            skid_pl_d    = w_dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pl_q     <= '0;
            out_valid_q  <= 1'b0;
            skid_pl_q    <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_pl_q     <= out_pl_d;
            out_valid_q  <= out_valid_d;
            skid_pl_q    <= skid_pl_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
    assign w_acc    = in_valid && in_ready && !flush;

    always_comb begin
        out_pl_d    = out_pl_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_ready) begin
            out_valid_d = w_acc;
            if (w_acc) begin
                out_pl_d = w_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pl_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_pl_q    <= out_pl_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign out_valid     = out_valid_q;
    assign out_op1       = out_pl_q.op1;
    assign out_op2       = out_pl_q.op2;
    assign out_op        = out_pl_q.op;
    assign out_is_cond   = out_pl_q.is_cond;
    assign out_rd        = out_pl_q.rd;
    assign out_wb_en     = out_pl_q.wb_en;
    assign out_br_target = out_pl_q.br_target;
    assign out_illegal   = out_pl_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Directed self-checking bench for alu_issue (either skid build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue;
    import alu_issue_pkg::*;

`ifdef ALU_ISSUE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [31:0]         in_instr = '0;
    logic [XLEN-1:0]     in_pc = '0;
    logic [4:0]          rs1_addr, rs2_addr;
    logic [XLEN-1:0]     rs1_data = '0;
    logic [XLEN-1:0]     rs2_data = '0;
    logic                flush = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [XLEN-1:0]     out_op1, out_op2, out_br_target;
    logic [ALU_OP_MSB:0] out_op;
    logic                out_is_cond, out_wb_en, out_illegal;
    logic [4:0]          out_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op1       (out_op1),
        .out_op2       (out_op2),
        .out_op        (out_op),
        .out_is_cond   (out_is_cond),
        .out_rd        (out_rd),
        .out_wb_en     (out_wb_en),
        .out_br_target (out_br_target),
        .out_illegal   (out_illegal)
    );

    typedef struct {
        logic [31:0] instr, pc, d1, d2, op1, op2, br;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wb, cond, ill;
    } vec_t;

    function automatic logic [31:0] addi_x5(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd5, 7'h13};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({out_valid, out_op1, out_op2, out_op, out_is_cond, out_rd, out_wb_en, out_br_target, out_illegal} !== '0) begin errors++; $display("FAIL reset_outputs: got valid=%b op1=%h op2=%h rd=%0d want all zero", out_valid, out_op1, out_op2, out_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        in_instr = 32'h002081B3; in_pc = 32'h0; rs1_data = 32'd5; rs2_data = 32'd7; in_valid = 1'b1;
        #1;
        checks++; if (rs1_addr !== 5'd1) begin errors++; $display("FAIL add_rs1_addr: got %0d want 1", rs1_addr); end
        checks++; if (rs2_addr !== 5'd2) begin errors++; $display("FAIL add_rs2_addr: got %0d want 2", rs2_addr); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
        checks++; if (out_op1 !== 32'd5) begin errors++; $display("FAIL add_op1: got %h want 5", out_op1); end
        checks++; if (out_op2 !== 32'd7) begin errors++; $display("FAIL add_op2: got %h want 7", out_op2); end
        checks++; if (out_op !== ALU_ADD) begin errors++; $display("FAIL add_op: got %0d want %0d", out_op, ALU_ADD); end
        checks++; if (out_rd !== 5'd3) begin errors++; $display("FAIL add_rd: got %0d want 3", out_rd); end
        checks++; if ({out_wb_en, out_is_cond, out_illegal} !== 3'b100) begin errors++; $display("FAIL add_flags: got wb/cond/ill=%b want 100", {out_wb_en, out_is_cond, out_illegal}); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", out_valid); end
    endtask

    // Table streamed back-to-back: one instruction per cycle with out_ready held high.
    task automatic test_decode_back_to_back();
        vec_t v[13];
        v[0]  = '{32'hFFF00093, 32'h0,    32'd0,         32'd0, 32'd0,         32'hFFFFFFFF, 32'h0,        4'd0,  5'd1, 1'b1, 1'b0, 1'b0};
        v[1]  = '{32'h00208463, 32'h100,  32'd9,         32'd9, 32'd9,         32'd9,        32'h108,      4'd10, 5'd0, 1'b0, 1'b1, 1'b0};
        v[2]  = '{32'h0020A463, 32'h100,  32'd9,         32'd9, 32'd0,         32'd0,        32'h0,        4'd0,  5'd0, 1'b0, 1'b0, 1'b1};
        v[3]  = '{32'h402081B3, 32'h0,    32'd10,        32'd3, 32'd10,        32'd3,        32'h0,        4'd1,  5'd3, 1'b1, 1'b0, 1'b0};
        v[4]  = '{32'h4050D193, 32'h0,    32'h80000000,  32'd1, 32'h80000000,  32'd5,        32'h0,        4'd7,  5'd3, 1'b1, 1'b0, 1'b0};
        v[5]  = '{32'h40509193, 32'h0,    32'd4,         32'd1, 32'd0,         32'd0,        32'h0,        4'd0,  5'd0, 1'b0, 1'b0, 1'b1};
        v[6]  = '{32'h12345037, 32'h40,   32'd7,         32'd1, 32'd0,         32'h12345000, 32'h0,        4'd0,  5'd0, 1'b0, 1'b0, 1'b0};
        v[7]  = '{32'h00001097, 32'h1000, 32'd7,         32'd1, 32'h1000,      32'h1000,     32'h0,        4'd0,  5'd1, 1'b1, 1'b0, 1'b0};
        v[8]  = '{32'hFE209EE3, 32'h0,    32'd1,         32'd2, 32'd1,         32'd2,        32'hFFFFFFFC, 4'd11, 5'd0, 1'b0, 1'b1, 1'b0};
        v[9]  = '{32'h0000007F, 32'h0,    32'd1,         32'd2, 32'd0,         32'd0,        32'h0,        4'd0,  5'd0, 1'b0, 1'b0, 1'b1};
        v[10] = '{32'h022081B3, 32'h0,    32'd1,         32'd2, 32'd0,         32'd0,        32'h0,        4'd0,  5'd0, 1'b0, 1'b0, 1'b1};
        v[11] = '{32'h4020D1B3, 32'h0,    32'hF0,        32'd4, 32'hF0,        32'd4,        32'h0,        4'd7,  5'd3, 1'b1, 1'b0, 1'b0};
        v[12] = '{32'hFFF0B113, 32'h0,    32'd3,         32'd4, 32'd3,         32'hFFFFFFFF, 32'h0,        4'd4,  5'd2, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_instr = v[i].instr; in_pc = v[i].pc; rs1_data = v[i].d1; rs2_data = v[i].d2; in_valid = 1'b1;
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if ({out_op1, out_op2, out_op, out_is_cond, out_rd, out_wb_en, out_br_target, out_illegal} !==
                          {v[i].op1, v[i].op2, v[i].op, v[i].cond, v[i].rd, v[i].wb, v[i].br, v[i].ill}) begin
                errors++;
                $display("FAIL decode[%0d]: got op1=%h op2=%h op=%0d cond=%b rd=%0d wb=%b br=%h ill=%b want op1=%h op2=%h op=%0d cond=%b rd=%0d wb=%b br=%h ill=%b",
                         i, out_op1, out_op2, out_op, out_is_cond, out_rd, out_wb_en, out_br_target, out_illegal,
                         v[i].op1, v[i].op2, v[i].op, v[i].cond, v[i].rd, v[i].wb, v[i].br, v[i].ill);
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_imm [4];
        logic [31:0] held;
        logic        held_v;
        int          idx, oidx, acc_cnt;
        exp_imm = '{32'd11, 32'd22, 32'd33, 32'd44};
        held = '0; held_v = 1'b0; idx = 0; oidx = 0; acc_cnt = 0;
        rs1_data = '0; rs2_data = '0; in_pc = '0;
        for (int c = 0; c < 40 && oidx < 4; c++) begin
            out_ready = (c >= 3);
            in_valid  = (idx < 4);
            in_instr  = (idx < 4) ? addi_x5(exp_imm[idx][11:0]) : 32'h0;
            #1;
            if (c < 3 && acc_cnt >= 1) begin
                checks++; if (in_ready !== (SKID && acc_cnt < 2)) begin errors++; $display("FAIL bp_in_ready[c%0d]: got %b want %b", c, in_ready, (SKID && acc_cnt < 2)); end
            end
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    checks++; if (out_op2 !== held) begin errors++; $display("FAIL bp_stable[c%0d]: got %h want %h", c, out_op2, held); end
                end
                held = out_op2; held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++; if ({out_op2, out_rd} !== {exp_imm[oidx], 5'd5}) begin errors++; $display("FAIL bp_order[%0d]: got op2=%h rd=%0d want op2=%h rd=5", oidx, out_op2, out_rd, exp_imm[oidx]); end
                oidx++;
            end
            if (in_valid && in_ready) begin
                idx++; acc_cnt++;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (oidx !== 4) begin errors++; $display("FAIL bp_count: got %0d outputs want 4", oidx); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        bit dropped;
        dropped = 1'b0;
        out_ready = 1'b0;
        rs1_data = '0; rs2_data = '0; in_pc = '0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_instr = addi_x5(12'd55 + 12'(k));
            #1;
            if (!in_ready) begin dropped = 1'b1; break; end
            step();
        end
        checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL flush_fill: in_ready got %b want 0 under stall", in_ready); end
        in_instr = addi_x5(12'd99); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_skid_empty: got %b want 0", out_valid); end
        in_instr = addi_x5(12'd77); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, out_op2} !== {1'b1, 32'd77}) begin errors++; $display("FAIL flush_post_issue: got valid=%b op2=%h want 1/%h", out_valid, out_op2, 32'd77); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_post_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        in_instr = addi_x5(12'd66); in_valid = 1'b1;
        step();
        in_instr = addi_x5(12'd67);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, out_op1, out_op2, out_op, out_is_cond, out_rd, out_wb_en, out_br_target, out_illegal} !== '0) begin errors++; $display("FAIL rst_async: got valid=%b op2=%h rd=%0d want all zero", out_valid, out_op2, out_rd); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale[%0d]: got %b want 0", k, out_valid); end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_decode_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
